mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter DATA_W, 32, data width of all data ports.
REQ-003 Parameter STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (range 1..15).
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Ports if_req in 1 / if_addr in ADDR_W  fetch request and word address.
REQ-007 Ports if_gnt out 1 / if_rvalid out 1 / if_rdata out DATA_W  fetch grant, response strobe, response data.
REQ-008 Ports dm_req in 1 / dm_we in 1 / dm_be in 4 / dm_addr in ADDR_W / dm_wdata in DATA_W  load/store request (byte or word).
REQ-009 Ports dm_gnt out 1 / dm_rvalid out 1 / dm_rdata out DATA_W  data grant, response or write-ack strobe, load data.
REQ-010 Ports mem_req out 1 / mem_we out 1 / mem_be out 4 / mem_addr out ADDR_W / mem_wdata out DATA_W  single shared memory port.
REQ-011 Ports mem_rvalid in 1 / mem_rdata in DATA_W  memory completion (read data or write ack), arbitrary latency >= 1 cycle.
REQ-012 Port busy  out  1  high while a transaction is outstanding.

Function
REQ-013 FSM states: IDLE, BUSY_IF, BUSY_DM; exactly one transaction outstanding at any time.
REQ-014 In IDLE with any request present, the winner's gnt and mem_req assert combinationally in that cycle, mem_* driven from the winner's inputs; FSM enters BUSY_IF/BUSY_DM at the next edge.
REQ-015 Requesters hold req and payload stable until gnt; gnt is a one-cycle pulse; non-winner gnt stays 0.
REQ-016 Default priority: data side wins when dm_req and if_req are both high.
REQ-017 mem_req, if_gnt and dm_gnt are 0 in BUSY_IF and BUSY_DM; new requests wait.
REQ-018 In BUSY_x, mem_rvalid=1 causes x_rvalid=1 and x_rdata=mem_rdata registered at the next edge, and FSM returns to IDLE at that same edge.
REQ-019 Response latency: x_rvalid rises exactly one cycle after mem_rvalid; grant-to-rvalid = memory latency + 1.
REQ-020 A new grant may issue in the same cycle x_rvalid is high (back-to-back, one idle-free cycle per transaction boundary).
REQ-021 dm_rdata is updated for writes too (value = mem_rdata, don't-care to consumer); if_rdata/dm_rdata hold value between responses.
REQ-022 mem_rvalid in IDLE is ignored: no rvalid, no state change.
REQ-023 busy = 1 in BUSY_IF and BUSY_DM, else 0.

Reset
REQ-024 reset low forces IDLE asynchronously; all registered outputs (if_rvalid, dm_rvalid, if_rdata, dm_rdata) reset to 0; starvation counter resets to 0.
REQ-025 Reset mid-transaction discards the outstanding transaction; a late mem_rvalid after release is ignored per REQ-022.

Configuration
REQ-026 Macro MEM_ARB_STARVE_GUARD_EN defined: a counter increments on each data grant issued while if_req is high, clears on any fetch grant; when counter == STARVE_LIMIT and if_req is high, fetch wins over data.
REQ-027 Macro undefined: strict data priority, no counter logic, STARVE_LIMIT unused.

Structure
REQ-028 Shared package holds the FSM state enum (IDLE, BUSY_IF, BUSY_DM) and the byte-enable constants BE_WORD=4'b1111, BE_NONE=4'b0000.
REQ-029 One sub-module, mem_arb_starve_ctr (starvation counter), instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-030 Fetch only: if_req, if_addr=0x100; memory replies mem_rdata=0xDEADBEEF 3 cycles after grant -> if_gnt pulse at cycle 0, if_rvalid at cycle 4 with if_rdata=0xDEADBEEF.
REQ-031 Simultaneous if_req and dm_req (load 0x200) -> dm_gnt first, mem_addr=0x200; if_gnt in the cycle dm_rvalid rises.
REQ-032 Store: dm_we=1, dm_be=4'b0001, dm_wdata=0xAB -> mem_we=1, mem_be=4'b0001, mem_wdata=0xAB; write-ack gives dm_rvalid one cycle later.
REQ-033 Guard enabled, STARVE_LIMIT=4, dm_req and if_req held high -> 4 data grants then 1 fetch grant, repeating; guard disabled -> fetch never granted.
REQ-034 Reset asserted in BUSY_DM, mem_rvalid arrives after release -> no dm_rvalid, busy=0, next request granted normally.
REQ-035 Spurious mem_rvalid in IDLE -> no rvalid outputs, state remains IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // One transaction outstanding at a time; the busy state records who owns it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Wide enough for a starvation limit of up to 15.
  localparam int unsigned STARVE_CTR_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter: counts data grants that went ahead while fetch was waiting
// and flags when fetch must be allowed through.
module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic data_gnt_i,
  input  logic fetch_req_i,
  input  logic fetch_gnt_i,
  output logic starved_o
);

  localparam logic [STARVE_CTR_W-1:0] LimitW = STARVE_CTR_W'(Limit);

  logic [STARVE_CTR_W-1:0] count_q, count_d;

  // Next count: clear on fetch grant, bump on a data grant that bypassed a waiting fetch.
  always_comb begin
    count_d = count_q;
    if (fetch_gnt_i) begin
      count_d = '0;
    end else if (data_gnt_i && fetch_req_i && (count_q < LimitW)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starved_o = fetch_req_i && (count_q == LimitW);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared memory port with a
// single outstanding transaction. Data side has priority by default.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let fetch win once data has
// been granted STARVE_LIMIT times in a row while fetch was waiting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  arb_state_e state_q;
  logic       idle;
  logic       fetch_starved;
  logic       fetch_wins;

  assign idle = (state_q == IDLE);
  assign busy = !idle;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .Limit (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i       (clk),
    .rst_ni      (reset),
    .data_gnt_i  (dm_gnt),
    .fetch_req_i (if_req),
    .fetch_gnt_i (if_gnt),
    .starved_o   (fetch_starved)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign fetch_starved       = 1'b0;
`endif

  // Grant decision: only in IDLE, data first unless fetch has been starved.
  always_comb begin
    fetch_wins = if_req && (!dm_req || fetch_starved);
    if_gnt     = idle && fetch_wins;
    dm_gnt     = idle && dm_req && !fetch_wins;
  end

  // Drive the shared memory port from whichever side won this cycle.
  always_comb begin
    mem_req   = if_gnt || dm_gnt;
    mem_we    = 1'b0;
    mem_be    = BE_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_be   = BE_WORD;
      mem_addr = if_addr;
    end
  end

  // Transaction FSM with registered response strobes and data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state_q)
        IDLE: begin
          // A completion seen here belongs to nobody and is dropped.
          if (dm_gnt) begin
            state_q <= BUSY_DM;
          end else if (if_gnt) begin
            state_q <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_rvalid) begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
            state_q   <= IDLE;
          end
        end
        BUSY_DM: begin
          // Write acks also land here; the data is meaningless to the consumer.
          if (mem_rvalid) begin
            dm_rvalid <= 1'b1;
            dm_rdata  <= mem_rdata;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Expected grant pattern under
// contention follows MEM_ARB_STARVE_GUARD_EN when that macro is defined.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [1:0] gnt_pair;
    logic [1:0] exp_pair;

    reset      = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_be      = 4'b0000;
    dm_addr    = '0;
    dm_wdata   = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_dm_rdata", dm_rdata, 32'h0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    reset = 1'b1;

    // Fetch only, memory latency 3
    tick();
    if_req  = 1'b1;
    if_addr = 32'h100;
    settle();
    check_eq("f_if_gnt", 32'(if_gnt), 32'd1);
    check_eq("f_dm_gnt", 32'(dm_gnt), 32'd0);
    check_eq("f_mem_req", 32'(mem_req), 32'd1);
    check_eq("f_mem_addr", mem_addr, 32'h100);
    check_eq("f_mem_we", 32'(mem_we), 32'd0);
    check_eq("f_mem_be", 32'(mem_be), 32'hF);
    tick();
    if_req = 1'b0;
    settle();
    check_eq("f_busy", 32'(busy), 32'd1);
    check_eq("f_gnt_pulse", 32'(if_gnt), 32'd0);
    check_eq("f_mem_req_busy", 32'(mem_req), 32'd0);
    tick();
    settle();
    check_eq("f_no_early_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("f_if_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("f_if_rdata", if_rdata, 32'hDEADBEEF);
    check_eq("f_busy_done", 32'(busy), 32'd0);
    tick();
    settle();
    check_eq("f_rvalid_pulse", 32'(if_rvalid), 32'd0);
    check_eq("f_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Simultaneous requests: data first, fetch granted back-to-back
    tick();
    if_req  = 1'b1;
    if_addr = 32'h100;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_be   = 4'hF;
    dm_addr = 32'h200;
    settle();
    check_eq("c_dm_gnt", 32'(dm_gnt), 32'd1);
    check_eq("c_if_gnt", 32'(if_gnt), 32'd0);
    check_eq("c_mem_addr", mem_addr, 32'h200);
    tick();
    dm_req     = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    settle();
    check_eq("c_if_wait", 32'(if_gnt), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("c_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check_eq("c_dm_rdata", dm_rdata, 32'h11223344);
    check_eq("c_if_gnt_b2b", 32'(if_gnt), 32'd1);
    check_eq("c_mem_addr_if", mem_addr, 32'h100);
    tick();
    if_req     = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE0001;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("c_if_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("c_if_rdata", if_rdata, 32'hCAFE0001);
    check_eq("c_dm_rdata_hold", dm_rdata, 32'h11223344);

    // Byte store and write ack
    tick();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b0001;
    dm_addr  = 32'h300;
    dm_wdata = 32'hAB;
    settle();
    check_eq("s_dm_gnt", 32'(dm_gnt), 32'd1);
    check_eq("s_mem_we", 32'(mem_we), 32'd1);
    check_eq("s_mem_be", 32'(mem_be), 32'h1);
    check_eq("s_mem_wdata", mem_wdata, 32'hAB);
    check_eq("s_mem_addr", mem_addr, 32'h300);
    tick();
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    settle();
    check_eq("s_no_early_ack", 32'(dm_rvalid), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("s_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check_eq("s_dm_rdata", dm_rdata, 32'h55);

    // Spurious completion in IDLE
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h99;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("sp_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("sp_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("sp_busy", 32'(busy), 32'd0);
    check_eq("sp_dm_rdata", dm_rdata, 32'h55);
    check_eq("sp_if_rdata", if_rdata, 32'hCAFE0001);

    // Reset during BUSY_DM, late completion afterwards
    tick();
    dm_req  = 1'b1;
    dm_be   = 4'hF;
    dm_addr = 32'h400;
    settle();
    check_eq("r_dm_gnt", 32'(dm_gnt), 32'd1);
    tick();
    dm_req = 1'b0;
    settle();
    check_eq("r_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("r_busy_async", 32'(busy), 32'd0);
    check_eq("r_dm_rdata_clr", dm_rdata, 32'h0);
    #1;
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("r_late_rvalid", 32'(dm_rvalid), 32'd0);
    check_eq("r_busy_after", 32'(busy), 32'd0);
    check_eq("r_dm_rdata_after", dm_rdata, 32'h0);
    dm_req  = 1'b1;
    dm_addr = 32'h500;
    settle();
    check_eq("r_regrant", 32'(dm_gnt), 32'd1);
    check_eq("r_regrant_addr", mem_addr, 32'h500);
    tick();
    dm_req     = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("r_rvalid", 32'(dm_rvalid), 32'd1);
    check_eq("r_rdata", dm_rdata, 32'h1234);

    // Sustained contention, memory latency 1
    tick();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_be   = 4'hF;
    dm_addr = 32'h600;
    if_req  = 1'b1;
    if_addr = 32'h104;
    for (int i = 0; i < 10; i++) begin
      settle();
      gnt_pair = {if_gnt, dm_gnt};
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_pair = ((i % 5) == 4) ? 2'b10 : 2'b01;
`else
      exp_pair = 2'b01;
`endif
      check_eq($sformatf("arb_round%0d", i), 32'(gnt_pair), 32'(exp_pair));
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'(i);
      tick();
      mem_rvalid = 1'b0;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
